// File: rtl/inst_trace_buffer.sv
// inst_trace_buffer: observe-only instruction trace buffer for single_period_cpu.
// Once armed, it waits for pc==trig_pc and then records {pc,inst} pairs until
// the buffer is full or stop is pulsed. The stored entries are then read out
// oldest-first through a valid/ready port.
// ADDR_LEN and INSTR_LEN mirror the widths in defines.v.
// Optional macro TRACE_DEDUP_EN: while capturing, skip the write when pc equals
// the pc of the last written entry. This collapses jump-to-self halt loops.
module inst_trace_buffer #(
   parameter int DEPTH     = 16,
   parameter int ADDR_LEN  = 32,
   parameter int INSTR_LEN = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [ADDR_LEN-1:0]    pc,
   input  logic [INSTR_LEN-1:0]   inst,
   input  logic                   arm,
   input  logic [ADDR_LEN-1:0]    trig_pc,
   input  logic                   stop,
   input  logic                   rd_ready,
   output logic                   rd_valid,
   output logic [ADDR_LEN-1:0]    rd_pc,
   output logic [INSTR_LEN-1:0]   rd_inst,
   output logic [1:0]             state,
   output logic [$clog2(DEPTH):0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] LAST = (AW+1)'(DEPTH - 1);
   localparam logic [AW:0] ONE  = (AW+1)'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DRAIN   = 2'd3
   } state_t;

   state_t st, nxt;

   logic [ADDR_LEN-1:0]  pc_mem   [DEPTH];
   logic [INSTR_LEN-1:0] inst_mem [DEPTH];
   logic [AW-1:0]        wr_ptr, rd_ptr;
   logic                 wr_en, pop, clr, dup;

`ifdef TRACE_DEDUP_EN
   logic [ADDR_LEN-1:0]  last_pc;

   // Remember the pc of the most recent written entry.
   always_ff @(posedge clk) begin
      if (rst)
         last_pc <= '0;
      else if (wr_en)
         last_pc <= pc;
   end

   assign dup = (pc == last_pc);
`else
   assign dup = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk) begin
      if (rst)
         st <= IDLE;
      else
         st <= nxt;
   end

   // Next-state logic and datapath strobes.
   always_comb begin
      nxt      = st;
      wr_en    = 1'b0;
      pop      = 1'b0;
      clr      = 1'b0;
      rd_valid = 1'b0;
      case (st)
         IDLE: begin
            if (arm) begin
               nxt = ARMED;
               clr = 1'b1;
            end
         end
         ARMED: begin
            if (stop)
               nxt = IDLE;
            else if (pc == trig_pc) begin
               wr_en = 1'b1;
               nxt   = CAPTURE;
            end
         end
         CAPTURE: begin
            if (stop)
               nxt = DRAIN;
            else if (!dup) begin
               wr_en = 1'b1;
               if (count == LAST)
                  nxt = DRAIN;
            end
         end
         DRAIN: begin
            rd_valid = (count != '0);
            if (rd_valid && rd_ready) begin
               pop = 1'b1;
               if (count == ONE)
                  nxt = IDLE;
            end else if (!rd_valid) begin
               nxt = IDLE;
            end
         end
         default: nxt = IDLE;
      endcase
   end

   // Pointers and occupancy. A write and a pop never happen in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr <= wr_ptr + 1'b1;
            count  <= count + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
            count  <= count - 1'b1;
         end
      end
   end

   // Trace storage. It is not reset; readout is masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (wr_en && !rst) begin
         pc_mem[wr_ptr]   <= pc;
         inst_mem[wr_ptr] <= inst;
      end
   end

   assign rd_pc   = (count != '0) ? pc_mem[rd_ptr]   : '0;
   assign rd_inst = (count != '0) ? inst_mem[rd_ptr] : '0;
   assign state   = st;

endmodule

// File: tb/tb_inst_trace_buffer.sv
// Directed self-checking bench for inst_trace_buffer (DEPTH=16, 32-bit pc/inst).
module tb_inst_trace_buffer;

   logic        clk = 1'b0;
   logic        rst, arm, stop, rd_ready, rd_valid;
   logic [31:0] pc, inst, trig_pc, rd_pc, rd_inst;
   logic [1:0]  state;
   logic [4:0]  count;

   int checks = 0;
   int errors = 0;

   inst_trace_buffer #(.DEPTH(16), .ADDR_LEN(32), .INSTR_LEN(32)) dut (
      .clk(clk), .rst(rst), .pc(pc), .inst(inst), .arm(arm),
      .trig_pc(trig_pc), .stop(stop), .rd_ready(rd_ready),
      .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_inst(rd_inst),
      .state(state), .count(count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [31:0] p);
      return p ^ 32'hA5A5_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic setpc(input logic [31:0] p);
      pc   = p;
      inst = inst_of(p);
   endtask

   task automatic start(input logic [31:0] t);
      trig_pc = t;
      arm     = 1'b1;
      tick();
      arm = 1'b0;
      chk("armed_state", 32'(state), 32'd1);
   endtask

   task automatic pop_expect(input logic [31:0] p);
      rd_ready = 1'b1;
      chk("pop_valid", 32'(rd_valid), 32'd1);
      chk("pop_pc", rd_pc, p);
      chk("pop_inst", rd_inst, inst_of(p));
      tick();
      rd_ready = 1'b0;
   endtask

   task automatic do_stop(input logic [31:0] p);
      stop = 1'b1;
      setpc(p);
      tick();
      stop = 1'b0;
   endtask

   logic [31:0] dd_pcs [5];
   logic [31:0] dd_exp [5];
   int          dd_n;

   initial begin
      rst = 1'b1; arm = 1'b0; stop = 1'b0; rd_ready = 1'b0;
      trig_pc = '0;
      setpc(32'h0);
      tick();
      rst = 1'b0;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_valid", 32'(rd_valid), 32'd0);
      chk("rst_rdpc", rd_pc, 32'd0);

      // Basic capture: trigger at 0x08, 16 entries, then full drain.
      start(32'h8);
      setpc(32'h4); tick();
      chk("basic_nomatch_state", 32'(state), 32'd1);
      chk("basic_nomatch_count", 32'(count), 32'd0);
      setpc(32'h8); tick();
      chk("basic_trig_state", 32'(state), 32'd2);
      chk("basic_trig_count", 32'(count), 32'd1);
      chk("basic_capture_valid", 32'(rd_valid), 32'd0);
      for (int i = 1; i < 16; i++) begin
         setpc(32'h8 + 32'(4 * i));
         tick();
         if (i == 14) begin
            chk("basic_15_state", 32'(state), 32'd2);
            chk("basic_15_count", 32'(count), 32'd15);
         end
      end
      chk("basic_full_state", 32'(state), 32'd3);
      chk("basic_full_count", 32'(count), 32'd16);
      setpc(32'h1000); tick();
      chk("basic_drain_nowrite", 32'(count), 32'd16);
      for (int i = 0; i < 16; i++)
         pop_expect(32'h8 + 32'(4 * i));
      chk("basic_end_state", 32'(state), 32'd0);
      chk("basic_end_count", 32'(count), 32'd0);
      chk("basic_end_valid", 32'(rd_valid), 32'd0);
      chk("basic_end_rdpc", rd_pc, 32'd0);

      // Early stop: stop-cycle pc must not be stored.
      start(32'h100);
      setpc(32'h100); tick();
      setpc(32'h104); tick();
      setpc(32'h108); tick();
      chk("stop_pre_count", 32'(count), 32'd3);
      do_stop(32'h10C);
      chk("stop_state", 32'(state), 32'd3);
      chk("stop_count", 32'(count), 32'd3);
      pop_expect(32'h100);
      pop_expect(32'h104);
      pop_expect(32'h108);
      chk("stop_end_state", 32'(state), 32'd0);
      chk("stop_end_valid", 32'(rd_valid), 32'd0);

      // Abort: stop beats a simultaneous trigger match.
      start(32'h200);
      setpc(32'h200);
      do_stop(32'h200);
      chk("abort_state", 32'(state), 32'd0);
      chk("abort_count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         chk("abort_valid", 32'(rd_valid), 32'd0);
         chk("abort_idle", 32'(state), 32'd0);
         tick();
      end

      // Backpressure: rd_ready 1,0,1,0 gives exactly two pops.
      start(32'h300);
      for (int i = 0; i < 4; i++) begin
         setpc(32'h300 + 32'(4 * i));
         tick();
      end
      do_stop(32'h310);
      chk("bp_count", 32'(count), 32'd4);
      chk("bp_state", 32'(state), 32'd3);
      rd_ready = 1'b1;
      chk("bp_c1_pc", rd_pc, 32'h300);
      tick();
      rd_ready = 1'b0;
      chk("bp_c2_pc", rd_pc, 32'h304);
      chk("bp_c2_valid", 32'(rd_valid), 32'd1);
      tick();
      chk("bp_c3_pc_stable", rd_pc, 32'h304);
      chk("bp_c3_count", 32'(count), 32'd3);
      rd_ready = 1'b1;
      tick();
      rd_ready = 1'b0;
      chk("bp_c4_pc", rd_pc, 32'h308);
      tick();
      chk("bp_after_count", 32'(count), 32'd2);
      chk("bp_after_pc", rd_pc, 32'h308);
      chk("bp_after_state", 32'(state), 32'd3);
      pop_expect(32'h308);
      pop_expect(32'h30C);
      chk("bp_end_state", 32'(state), 32'd0);

      // Reset mid-drain with arm held during reset.
      start(32'h400);
      for (int i = 0; i < 9; i++) begin
         setpc(32'h400 + 32'(4 * i));
         tick();
      end
      do_stop(32'h500);
      chk("rstd_count", 32'(count), 32'd9);
      chk("rstd_state", 32'(state), 32'd3);
      rst = 1'b1; arm = 1'b1; rd_ready = 1'b1;
      tick();
      rst = 1'b0; arm = 1'b0; rd_ready = 1'b0;
      chk("rstd_post_state", 32'(state), 32'd0);
      chk("rstd_post_count", 32'(count), 32'd0);
      chk("rstd_post_valid", 32'(rd_valid), 32'd0);
      chk("rstd_post_rdpc", rd_pc, 32'd0);
      tick();
      chk("rstd_arm_ignored", 32'(state), 32'd0);
      start(32'h500);
      chk("rstd_rearm_count", 32'(count), 32'd0);
      setpc(32'h500); tick();
      chk("rstd_retrig_state", 32'(state), 32'd2);
      chk("rstd_retrig_count", 32'(count), 32'd1);
      do_stop(32'h504);
      pop_expect(32'h500);
      chk("rstd_end_state", 32'(state), 32'd0);

      // Repeated pc: collapsed with TRACE_DEDUP_EN, all written otherwise.
      dd_pcs = '{32'h10, 32'h14, 32'h14, 32'h14, 32'h18};
`ifdef TRACE_DEDUP_EN
      dd_n   = 3;
      dd_exp = '{32'h10, 32'h14, 32'h18, 32'h0, 32'h0};
`else
      dd_n   = 5;
      dd_exp = '{32'h10, 32'h14, 32'h14, 32'h14, 32'h18};
`endif
      start(32'h10);
      for (int i = 0; i < 5; i++) begin
         setpc(dd_pcs[i]);
         tick();
      end
      do_stop(32'h1C);
      chk("dedup_count", 32'(count), 32'(dd_n));
      chk("dedup_state", 32'(state), 32'd3);
      for (int i = 0; i < dd_n; i++)
         pop_expect(dd_exp[i]);
      chk("dedup_end_state", 32'(state), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

endmodule
